strobe_lock_monitor: RTL and testbench



---
 rtl/strobe_lock_monitor_if.sv | 26 ++
 rtl/strobe_lock_monitor.sv | 176 +++++++++++++++++
 tb/tb_strobe_lock_monitor.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/strobe_lock_monitor_if.sv
// Signal bundle between the clock-divider side and the strobe lock monitor.
// strobe is a single-cycle qualifier with no backpressure; unlock is sampled every cycle.
interface strobe_lock_monitor_if #(
    parameter int CW = 8
);
    logic          enable;
    logic          strobe;
    logic          unlock;
    logic          err_clr;
    logic          locked;
    logic          period_err;
    logic          window_err;
    logic [CW-1:0] phase;
    logic [CW-1:0] last_period;
    logic [15:0]   err_count;

    modport master (
        output enable, strobe, unlock, err_clr,
        input  locked, period_err, window_err, phase, last_period, err_count
    );

    modport slave (
        input  enable, strobe, unlock, err_clr,
        output locked, period_err, window_err, phase, last_period, err_count
    );
endinterface

// File: rtl/strobe_lock_monitor.sv
// Fast-clock checker for the divided strobe and unlock window: measures strobe
// intervals, checks window phase, tracks lock and counts error events.
module strobe_lock_monitor #(
    parameter int PERIOD    = 15,
    parameter int TOL       = 0,
    parameter int WIN_START = 2,
    parameter int WIN_END   = 13,
    parameter int LOCK_N    = 4,
    parameter int UNLOCK_N  = 2,
    parameter int CW        = 8
) (
    input  logic                 clock,
    input  logic                 reset_n,
    strobe_lock_monitor_if.slave bus,
    output logic [1:0]           o_dbg_state
);
    localparam int GW = $clog2(LOCK_N + 1);
    localparam int BW = $clog2(UNLOCK_N + 1);
    localparam logic [GW-1:0] LOCK_V   = GW'(LOCK_N);
    localparam logic [BW-1:0] UNLOCK_V = BW'(UNLOCK_N);

    typedef enum logic [1:0] {
        S_SEARCH  = 2'd0,
        S_ACQUIRE = 2'd1,
        S_LOCKED  = 2'd2
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_last_period;
    logic [GW-1:0] r_good_cnt;
    logic [BW-1:0] r_bad_cnt;
    logic          r_win_bad;
    logic          r_locked;
    logic          r_period_err;
    logic          r_window_err;
    logic [15:0]   r_err_count;

    logic [CW-1:0] w_p;
    int            w_p_i;
    int            w_cnt_i;
    logic          w_active;
    logic          w_exp_unlock;
    logic          w_mismatch;
    logic          w_meas_ok;
    logic          w_bad_interval;
    logic          w_timeout;
    logic          w_good;
    logic          w_err_event;
    logic [GW-1:0] w_good_inc;
    logic [BW-1:0] w_bad_inc;
    logic [CW-1:0] w_cnt_inc;

    always_comb begin
        w_active       = (r_state != S_SEARCH);
        w_p            = bus.strobe ? '0 : r_cnt;
        w_p_i          = 32'(w_p);
        w_cnt_i        = 32'(r_cnt);
        w_exp_unlock   = (w_p_i >= WIN_START) && (w_p_i <= WIN_END);
        w_mismatch     = w_active && (bus.unlock != w_exp_unlock);
        w_meas_ok      = (w_cnt_i >= PERIOD - TOL) && (w_cnt_i <= PERIOD + TOL);
        w_bad_interval = w_active && bus.strobe && !w_meas_ok;
        // Reaching the upper tolerance without a strobe means the strobe is already late.
        w_timeout      = w_active && !bus.strobe && (w_cnt_i == PERIOD + TOL);
        // r_win_bad is the pre-strobe value, so a strobe-cycle mismatch lands in the next period.
        w_good         = w_meas_ok && !r_win_bad;
        w_err_event    = w_mismatch || w_bad_interval || w_timeout;
        w_good_inc     = r_good_cnt + GW'(1);
        w_bad_inc      = r_bad_cnt + BW'(1);
        w_cnt_inc      = (r_cnt == '1) ? r_cnt : r_cnt + CW'(1);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_SEARCH;
            r_cnt         <= '0;
            r_last_period <= '0;
            r_good_cnt    <= '0;
            r_bad_cnt     <= '0;
            r_win_bad     <= 1'b0;
            r_locked      <= 1'b0;
            r_period_err  <= 1'b0;
            r_window_err  <= 1'b0;
            r_err_count   <= '0;
        end else if (!bus.enable) begin
            r_state      <= S_SEARCH;
            r_cnt        <= '0;
            r_good_cnt   <= '0;
            r_bad_cnt    <= '0;
            r_win_bad    <= 1'b0;
            r_locked     <= 1'b0;
            r_period_err <= 1'b0;
            r_window_err <= 1'b0;
            if (bus.err_clr) r_err_count <= '0;
        end else begin
            r_window_err <= w_mismatch;
            r_period_err <= w_bad_interval || w_timeout;

            if (bus.err_clr)                             r_err_count <= '0;
            else if (w_err_event && r_err_count != '1)   r_err_count <= r_err_count + 16'd1;

            if (w_active && bus.strobe) r_last_period <= r_cnt;

            if (bus.strobe) r_win_bad <= w_mismatch;
            else            r_win_bad <= r_win_bad | w_mismatch;

            r_cnt <= bus.strobe ? CW'(1) : w_cnt_inc;

            case (r_state)
                S_SEARCH: begin
                    r_cnt <= '0;
                    if (bus.strobe) begin
                        r_state    <= S_ACQUIRE;
                        r_cnt      <= CW'(1);
                        r_good_cnt <= '0;
                        r_bad_cnt  <= '0;
                    end
                end
                S_ACQUIRE: begin
                    if (w_timeout) begin
                        r_state    <= S_SEARCH;
                        r_cnt      <= '0;
                        r_good_cnt <= '0;
                        r_win_bad  <= 1'b0;
                    end else if (bus.strobe) begin
                        if (!w_good) begin
                            r_good_cnt <= '0;
                        end else if (w_good_inc == LOCK_V) begin
                            r_state    <= S_LOCKED;
                            r_locked   <= 1'b1;
                            r_good_cnt <= '0;
                            r_bad_cnt  <= '0;
                        end else begin
                            r_good_cnt <= w_good_inc;
                        end
                    end
                end
                S_LOCKED: begin
                    if (w_timeout) begin
                        r_state    <= S_SEARCH;
                        r_locked   <= 1'b0;
                        r_cnt      <= '0;
                        r_good_cnt <= '0;
                        r_bad_cnt  <= '0;
                        r_win_bad  <= 1'b0;
                    end else if (bus.strobe) begin
                        if (w_good) begin
                            r_bad_cnt <= '0;
                        end else if (w_bad_inc == UNLOCK_V) begin
                            // This strobe becomes the reference for reacquisition.
                            r_state    <= S_ACQUIRE;
                            r_locked   <= 1'b0;
                            r_good_cnt <= '0;
                            r_bad_cnt  <= '0;
                        end else begin
                            r_bad_cnt <= w_bad_inc;
                        end
                    end
                end
                default: begin
                    r_state  <= S_SEARCH;
                    r_locked <= 1'b0;
                    r_cnt    <= '0;
                end
            endcase
        end
    end

    assign bus.locked      = r_locked;
    assign bus.period_err  = r_period_err;
    assign bus.window_err  = r_window_err;
    assign bus.phase       = r_cnt;
    assign bus.last_period = r_last_period;
    assign bus.err_count   = r_err_count;
    assign o_dbg_state     = r_state;
endmodule

// File: tb/tb_strobe_lock_monitor.sv
// Bench for strobe_lock_monitor: period-level vector table plus hand-written
// sequences for timeout, async reset, enable, back-to-back strobes and saturation.
module tb_strobe_lock_monitor;
    localparam int CW        = 8;
    localparam int W         = 3 + CW;
    localparam int WIN_START = 2;
    localparam int WIN_END   = 13;

    // One record is one strobe interval: len cycles, strobe on the last one.
    // bad_ph flips unlock at that cycle index (len = the strobe cycle, 0 = none).
    typedef struct {
        int len;
        int bad_ph;
        bit perr;
        bit locked;
        int state;
        int last;
    } vec_t;

    logic       clock;
    logic       reset_n;
    logic [1:0] dbg_state;

    int         total;
    int         bad;
    int         exp_errs;
    bit         cur_locked;
    logic [W-1:0] exp_q[$];
    vec_t       vecs[23];

    strobe_lock_monitor_if #(.CW(CW)) bus();

    strobe_lock_monitor #(.CW(CW)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] mk(input bit l, input bit pe, input bit we, input int ph);
        return {l, pe, we, CW'(ph)};
    endfunction

    function automatic bit ideal_unlock(input int p);
        return (p >= WIN_START) && (p <= WIN_END);
    endfunction

    // Drive one cycle, queue its expected {locked, period_err, window_err, phase}, compare.
    task automatic step(input string ctx, input logic s, input logic u, input logic clr,
                        input logic [W-1:0] e);
        logic [W-1:0] got;
        logic [W-1:0] want;
        bus.strobe  = s;
        bus.unlock  = u;
        bus.err_clr = clr;
        exp_q.push_back(e);
        if (e[W-2] || e[W-3]) exp_errs++;
        @(posedge clock);
        #1;
        got  = {bus.locked, bus.period_err, bus.window_err, bus.phase};
        want = exp_q.pop_front();
        chk(ctx, 32'(got), 32'(want));
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        for (int k = 1; k <= v.len; k++) begin
            bit s;
            bit w;
            bit u;
            int p;
            s = (k == v.len);
            p = s ? 0 : k;
            w = (k == v.bad_ph);
            u = ideal_unlock(p) ^ w;
            step($sformatf("vec%0d k%0d", idx, k), s, u, 1'b0,
                 mk(s ? v.locked : cur_locked, s ? v.perr : 1'b0, w, s ? 1 : k + 1));
        end
        cur_locked = v.locked;
        chk($sformatf("vec%0d last_period", idx), 32'(bus.last_period), 32'(v.last));
        chk($sformatf("vec%0d state", idx), 32'(dbg_state), 32'(v.state));
        chk($sformatf("vec%0d err_count", idx), 32'(bus.err_count), 32'(exp_errs));
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        exp_errs   = 0;
        cur_locked = 1'b0;

        vecs[0]  = '{15, 0,  0, 0, 1, 15};
        vecs[1]  = '{15, 0,  0, 0, 1, 15};
        vecs[2]  = '{15, 0,  0, 0, 1, 15};
        vecs[3]  = '{15, 0,  0, 1, 2, 15};
        vecs[4]  = '{14, 0,  1, 1, 2, 14};
        vecs[5]  = '{15, 0,  0, 1, 2, 15};
        vecs[6]  = '{14, 0,  1, 1, 2, 14};
        vecs[7]  = '{14, 0,  1, 0, 1, 14};
        vecs[8]  = '{15, 0,  0, 0, 1, 15};
        vecs[9]  = '{15, 0,  0, 0, 1, 15};
        vecs[10] = '{15, 0,  0, 0, 1, 15};
        vecs[11] = '{15, 0,  0, 1, 2, 15};
        vecs[12] = '{15, 14, 0, 1, 2, 15};
        vecs[13] = '{15, 0,  0, 1, 2, 15};
        vecs[14] = '{15, 5,  0, 1, 2, 15};
        vecs[15] = '{15, 5,  0, 0, 1, 15};
        vecs[16] = '{15, 0,  0, 0, 1, 15};
        vecs[17] = '{15, 15, 0, 0, 1, 15};
        vecs[18] = '{15, 0,  0, 0, 1, 15};
        vecs[19] = '{15, 0,  0, 0, 1, 15};
        vecs[20] = '{15, 0,  0, 0, 1, 15};
        vecs[21] = '{15, 0,  0, 0, 1, 15};
        vecs[22] = '{15, 0,  0, 1, 2, 15};

        // Clock/reset
        reset_n     = 1'b0;
        bus.enable  = 1'b1;
        bus.strobe  = 1'b0;
        bus.unlock  = 1'b0;
        bus.err_clr = 1'b0;
        @(posedge clock);
        #1;
        chk("reset outputs", {bus.locked, bus.period_err, bus.window_err}, 32'd0);
        chk("reset phase", 32'(bus.phase), 32'd0);
        chk("reset last_period", 32'(bus.last_period), 32'd0);
        chk("reset err_count", 32'(bus.err_count), 32'd0);
        chk("reset state", 32'(dbg_state), 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 3; i++)
            step("search idle", 1'b0, 1'($urandom_range(0, 1)), 1'b0, mk(0, 0, 0, 0));
        step("first ref", 1'b1, 1'b0, 1'b0, mk(0, 0, 0, 1));

        for (int i = 0; i < 23; i++) run_vec(vecs[i], i);

        // Strobe stops while locked: timeout on the phase-15 cycle.
        for (int k = 1; k <= 14; k++)
            step("timeout pre", 1'b0, ideal_unlock(k), 1'b0, mk(1, 0, 0, k + 1));
        step("timeout hit", 1'b0, 1'b0, 1'b0, mk(0, 1, 0, 0));
        step("timeout after", 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0));
        chk("timeout state", 32'(dbg_state), 32'd0);
        chk("timeout err_count", 32'(bus.err_count), 32'(exp_errs));
        cur_locked = 1'b0;

        step("relock ref", 1'b1, 1'b0, 1'b0, mk(0, 0, 0, 1));
        for (int i = 0; i < 4; i++) run_vec(vecs[i], 100 + i);

        // Asynchronous reset between edges while locked.
        #2;
        reset_n = 1'b0;
        #1;
        chk("async locked", 32'(bus.locked), 32'd0);
        chk("async phase", 32'(bus.phase), 32'd0);
        chk("async last_period", 32'(bus.last_period), 32'd0);
        chk("async err_count", 32'(bus.err_count), 32'd0);
        chk("async state", 32'(dbg_state), 32'd0);
        exp_errs   = 0;
        cur_locked = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++)
            step("post reset idle", 1'b0, 1'($urandom_range(0, 1)), 1'b0, mk(0, 0, 0, 0));

        // Back-to-back strobes: the second one measures a period of 1.
        step("b2b first", 1'b1, 1'b0, 1'b0, mk(0, 0, 0, 1));
        step("b2b second", 1'b1, 1'b0, 1'b0, mk(0, 1, 0, 1));
        chk("b2b last_period", 32'(bus.last_period), 32'd1);
        chk("b2b err_count", 32'(bus.err_count), 32'd1);
        chk("b2b state", 32'(dbg_state), 32'd1);

        // Disabled: forced to SEARCH, no errors, last_period and err_count hold.
        bus.enable = 1'b0;
        step("disabled strobe", 1'b1, 1'b1, 1'b0, mk(0, 0, 0, 0));
        step("disabled idle", 1'b0, 1'b1, 1'b0, mk(0, 0, 0, 0));
        chk("disabled state", 32'(dbg_state), 32'd0);
        chk("disabled last_period", 32'(bus.last_period), 32'd1);
        chk("disabled err_count", 32'(bus.err_count), 32'd1);
        bus.enable = 1'b1;

        // Saturation: strobe held high gives a bad period every cycle.
        bus.strobe = 1'b1;
        bus.unlock = 1'b0;
        repeat (65540) @(posedge clock);
        #1;
        chk("sat err_count", 32'(bus.err_count), 32'd65535);
        chk("sat period_err", 32'(bus.period_err), 32'd1);
        @(posedge clock);
        #1;
        chk("sat hold", 32'(bus.err_count), 32'd65535);

        step("clr with werr", 1'b1, 1'b1, 1'b1, mk(0, 1, 1, 1));
        chk("clr err_count", 32'(bus.err_count), 32'd0);
        step("after clr quiet", 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 2));
        chk("after clr count", 32'(bus.err_count), 32'd0);
        step("after clr werr", 1'b0, 1'b0, 1'b0, mk(0, 0, 1, 3));
        chk("after clr count1", 32'(bus.err_count), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
